estimador_loop_ctrl: RTL and testbench

Sequencing and data-select primitive for the estimador loop wrappers. It contains two independent parts. The first is a flow-control core that converts the parent's `ap_start`/`ap_ready`/`ap_done` handshake into per-iteration signals for a single-state loop body: `ap_start_int`, `ap_loop_init` and `ap_continue_int`. The second is a 3-input, width-parameterised word selector that loop bodies use to pick an element (or constant) by loop index.

---
 rtl/estimador_loop_ctrl.sv | 87 ++++++++
 tb/tb_estimador_loop_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/estimador_loop_ctrl.sv
// ============================================================================
// Module : estimador_loop_ctrl
// Brief  : Loop flow-control core plus a 3-input word selector.
//          ESTIMADOR_LOOP_CTRL_MUX_REG_EN registers the selector output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module estimador_loop_ctrl #(
    parameter int DIN_WIDTH = 32,
    parameter int SEL_WIDTH = 2
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    output logic                 ap_ready,
    output logic                 ap_done,
    output logic                 ap_start_int,
    output logic                 ap_loop_init,
    input  logic                 ap_ready_int,
    input  logic                 ap_loop_exit_ready,
    input  logic                 ap_loop_exit_done,
    output logic                 ap_continue_int,
    input  logic [DIN_WIDTH-1:0] din0,
    input  logic [DIN_WIDTH-1:0] din1,
    input  logic [DIN_WIDTH-1:0] din2,
    input  logic [SEL_WIDTH-1:0] sel,
    output logic [DIN_WIDTH-1:0] dout
);

    logic                 r_loop_init;
    logic                 r_done_cache;
    logic [DIN_WIDTH-1:0] w_stage1;
    logic [DIN_WIDTH-1:0] w_mux;

    assign ap_start_int    = ap_start;
    assign ap_continue_int = 1'b1;
    assign ap_ready        = ap_loop_exit_ready;
    assign ap_loop_init    = r_loop_init;

    // Exit takes priority so the next run starts with init asserted again.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_loop_init <= 1'b1;
        end else if (ap_loop_exit_ready) begin
            r_loop_init <= 1'b1;
        end else if (ap_ready_int) begin
            r_loop_init <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_done_cache <= 1'b0;
        end else if (ap_loop_exit_done) begin
            r_done_cache <= 1'b1;
        end else if (ap_start_int) begin
            r_done_cache <= 1'b0;
        end
    end

    assign ap_done = (!ap_loop_exit_done && !ap_start_int) ? r_done_cache
                                                           : ap_loop_exit_done;

    // Two-stage decode: sel[0] picks within the low pair, sel[1] selects din2.
    assign w_stage1 = sel[0] ? din1 : din0;
    assign w_mux    = sel[1] ? din2 : w_stage1;

`ifdef ESTIMADOR_LOOP_CTRL_MUX_REG_EN
    logic [DIN_WIDTH-1:0] r_dout;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_dout <= '0;
        end else begin
            r_dout <= w_mux;
        end
    end

    assign dout = r_dout;
`else
    assign dout = w_mux;
`endif

endmodule

`default_nettype wire

// File: tb/tb_estimador_loop_ctrl.sv
// ============================================================================
// Module : tb_estimador_loop_ctrl
// Brief  : Directed self-checking bench for estimador_loop_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_estimador_loop_ctrl;

    logic        clk;
    logic        rst;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_start_int;
    logic        ap_loop_init;
    logic        ap_ready_int;
    logic        ap_loop_exit_ready;
    logic        ap_loop_exit_done;
    logic        ap_continue_int;
    logic [31:0] din0;
    logic [31:0] din1;
    logic [31:0] din2;
    logic [1:0]  sel;
    logic [31:0] dout;

    int checks = 0;
    int errors = 0;

    estimador_loop_ctrl #(
        .DIN_WIDTH(32),
        .SEL_WIDTH(2)
    ) dut (
        .ap_clk             (clk),
        .ap_rst             (rst),
        .ap_start           (ap_start),
        .ap_ready           (ap_ready),
        .ap_done            (ap_done),
        .ap_start_int       (ap_start_int),
        .ap_loop_init       (ap_loop_init),
        .ap_ready_int       (ap_ready_int),
        .ap_loop_exit_ready (ap_loop_exit_ready),
        .ap_loop_exit_done  (ap_loop_exit_done),
        .ap_continue_int    (ap_continue_int),
        .din0               (din0),
        .din1               (din1),
        .din2               (din2),
        .sel                (sel),
        .dout               (dout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic s, input logic r, input logic er, input logic ed);
        @(negedge clk);
        ap_start           = s;
        ap_ready_int       = r;
        ap_loop_exit_ready = er;
        ap_loop_exit_done  = ed;
        #1;
    endtask

    function automatic logic [31:0] mux_model(input logic [1:0] s, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            default: return c;
        endcase
    endfunction

    task automatic sweep(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [7:0] order);
        logic [1:0]  s_seq [4];
        logic [31:0] exp_q [4];
        for (int i = 0; i < 4; i++) begin
            s_seq[i] = order[2*i +: 2];
            exp_q[i] = mux_model(s_seq[i], a, b, c);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            din0 = a;
            din1 = b;
            din2 = c;
            if (i < 4) sel = s_seq[i];
            #1;
`ifdef ESTIMADOR_LOOP_CTRL_MUX_REG_EN
            if (i > 0) check($sformatf("dout_reg_sel%0d", s_seq[i-1]), dout, exp_q[i-1]);
`else
            if (i < 4) check($sformatf("dout_sel%0d", s_seq[i]), dout, exp_q[i]);
`endif
        end
    endtask

    initial begin
        rst                = 1'b1;
        ap_start           = 1'b0;
        ap_ready_int       = 1'b0;
        ap_loop_exit_ready = 1'b0;
        ap_loop_exit_done  = 1'b0;
        din0 = 32'h0; din1 = 32'h0; din2 = 32'h0; sel = 2'd0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_loop_init", {31'b0, ap_loop_init}, 32'd1);
        check("rst_done", {31'b0, ap_done}, 32'd0);
        check("rst_continue", {31'b0, ap_continue_int}, 32'd1);
        check("rst_dout", dout, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_dout", dout, 32'h0);

        // Three-iteration run with exit in cycle 4.
        drive(1, 1, 0, 0);
        check("c1_init", {31'b0, ap_loop_init}, 32'd1);
        check("c1_start_int", {31'b0, ap_start_int}, 32'd1);
        check("c1_ready", {31'b0, ap_ready}, 32'd0);
        check("c1_done", {31'b0, ap_done}, 32'd0);
        drive(1, 1, 0, 0);
        check("c2_init", {31'b0, ap_loop_init}, 32'd0);
        check("c2_done", {31'b0, ap_done}, 32'd0);
        drive(1, 1, 0, 0);
        check("c3_init", {31'b0, ap_loop_init}, 32'd0);
        check("c3_ready", {31'b0, ap_ready}, 32'd0);
        drive(1, 1, 1, 1);
        check("c4_init", {31'b0, ap_loop_init}, 32'd0);
        check("c4_ready", {31'b0, ap_ready}, 32'd1);
        check("c4_done", {31'b0, ap_done}, 32'd1);
        drive(0, 0, 0, 0);
        check("c5_init", {31'b0, ap_loop_init}, 32'd1);
        check("c5_ready", {31'b0, ap_ready}, 32'd0);
        check("c5_done_hold", {31'b0, ap_done}, 32'd1);
        check("c5_start_int", {31'b0, ap_start_int}, 32'd0);
        drive(0, 0, 0, 0);
        check("c6_done_hold", {31'b0, ap_done}, 32'd1);
        drive(1, 0, 0, 0);
        check("c7_done_start", {31'b0, ap_done}, 32'd0);
        check("c7_init_hold", {31'b0, ap_loop_init}, 32'd1);
        drive(0, 0, 0, 0);
        check("c8_done_cleared", {31'b0, ap_done}, 32'd0);

        // Simultaneous ready_int and exit_ready.
        drive(1, 1, 0, 0);
        check("c9_init", {31'b0, ap_loop_init}, 32'd1);
        drive(1, 0, 0, 0);
        check("c10_init_clr", {31'b0, ap_loop_init}, 32'd0);
        drive(1, 1, 1, 0);
        check("c11_init_hold", {31'b0, ap_loop_init}, 32'd0);
        check("c11_ready", {31'b0, ap_ready}, 32'd1);
        check("c11_done", {31'b0, ap_done}, 32'd0);
        drive(0, 0, 0, 0);
        check("c12_init_exit_wins", {31'b0, ap_loop_init}, 32'd1);
        check("c12_done", {31'b0, ap_done}, 32'd0);

        // Simultaneous exit_done and start: cache sets.
        drive(1, 0, 0, 1);
        check("c13_done", {31'b0, ap_done}, 32'd1);
        drive(0, 0, 0, 0);
        check("c14_done_cached", {31'b0, ap_done}, 32'd1);

        // Mid-run asynchronous reset with init cleared and done cached.
        drive(0, 1, 0, 0);
        check("c15_done", {31'b0, ap_done}, 32'd1);
        drive(0, 0, 0, 0);
        check("c16_init", {31'b0, ap_loop_init}, 32'd0);
        check("c16_done", {31'b0, ap_done}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_init", {31'b0, ap_loop_init}, 32'd1);
        check("arst_done", {31'b0, ap_done}, 32'd0);
        ap_start = 1'b1;
        ap_loop_exit_done = 1'b1;
        #1;
        check("arst_done_passthru", {31'b0, ap_done}, 32'd1);
        ap_loop_exit_done = 1'b0;
        #1;
        check("arst_done_start", {31'b0, ap_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ap_start = 1'b0;
        #1;
        check("rel_init", {31'b0, ap_loop_init}, 32'd1);
        check("rel_done", {31'b0, ap_done}, 32'd0);

        // Selector sweeps.
        sweep(32'hFFF60000, 32'hFFF9B781, 32'hFFFF0000, {2'd3, 2'd2, 2'd1, 2'd0});
        sweep(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, {2'd2, 2'd0, 2'd1, 2'd3});

`ifdef ESTIMADOR_LOOP_CTRL_MUX_REG_EN
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_dout_reg", dout, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_dout_reg", dout, 32'h0);
`else
        @(negedge clk);
        sel = 2'd0;
        #1;
        check("dout_back_sel0", dout, 32'h12345678);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
